// File: rtl/alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_sequencer (with p18240_alu_pkg)
// Purpose  : Multi-cycle unsigned 16x16 shift-and-add multiply controller.
//            Borrows the p18240 ALU while busy: each iteration issues an
//            add (or pass-through), a left shift of the multiplicand and a
//            logical right shift of the multiplier. It stops as soon as the
//            remaining multiplier reaches zero. It returns the low 16 product
//            bits and a sticky unsigned-overflow flag.
// Ports    : clock, reset_L (async, active low)
//            start, multiplicand[15:0], multiplier[15:0]  - request
//            busy, done, product[15:0], overflow          - handshake/result
//            alu_op, alu_inA[15:0], alu_inB[15:0]         - to ALU
//            alu_out[15:0], alu_cc[3:0] {Z,C,N,V}         - from ALU
// Revision : 1.0 - initial release
// ============================================================================

package p18240_alu_pkg;
  typedef enum logic [3:0] {
    F_A        = 4'h0,
    F_A_PLUS_B = 4'h1,
    F_A_SHL    = 4'h2,
    F_A_LSHR   = 4'h3
  } alu_op_t;
endpackage

module alu_mult_sequencer
  import p18240_alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_L,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        overflow,
  output alu_op_t     alu_op,
  output logic [15:0] alu_inA,
  output logic [15:0] alu_inB,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_cc
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_acc;
  logic [15:0] r_mc;
  logic [15:0] r_mp;
  logic        r_lost;
  logic        r_ovf;

  logic        w_z;
  logic        w_c;
  logic        w_unused_cc;

  assign w_z = alu_cc[3];
  assign w_c = alu_cc[2];
  // N and V are meaningless for unsigned multiplication.
  assign w_unused_cc = ^alu_cc[1:0];

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and ALU drive; everything here depends only on the state
  // and internal registers, so start never reaches an output combinationally.
  always_comb begin
    w_next  = r_state;
    alu_op  = F_A;
    alu_inA = 16'h0000;
    alu_inB = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (multiplier == 16'h0000) ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        alu_inA = r_acc;
        if (r_mp[0]) begin
          alu_op  = F_A_PLUS_B;
          alu_inB = r_mc;
        end
        w_next = S_SHL;
      end
      S_SHL: begin
        alu_op  = F_A_SHL;
        alu_inA = r_mc;
        w_next  = S_SHR;
      end
      S_SHR: begin
        alu_op  = F_A_LSHR;
        alu_inA = r_mp;
        // Zero remaining multiplier means no further adds can change acc.
        w_next  = w_z ? S_DONE : S_ADD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_acc  <= 16'h0000;
      r_mc   <= 16'h0000;
      r_mp   <= 16'h0000;
      r_lost <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= 16'h0000;
            r_mc   <= multiplicand;
            r_mp   <= multiplier;
            r_lost <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_ADD: begin
          if (r_mp[0]) begin
            r_acc <= alu_out;
            // An add after a multiplicand bit fell off the top means the
            // true addend was at least 2^16, even if this add has no carry.
            r_ovf <= r_ovf | w_c | r_lost;
          end
        end
        S_SHL: begin
          r_mc   <= alu_out;
          r_lost <= r_lost | w_c;
        end
        S_SHR: begin
          r_mp <= alu_out;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign product  = r_acc;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mult_sequencer
// Purpose  : Directed self-checking bench for alu_mult_sequencer with a
//            behavioural model of the combinational p18240 ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mult_sequencer;
  import p18240_alu_pkg::*;

  logic        clock;
  logic        reset_L;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        overflow;
  alu_op_t     alu_op;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic [15:0] alu_out;
  logic [3:0]  alu_cc;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mult_sequencer dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .overflow     (overflow),
    .alu_op       (alu_op),
    .alu_inA      (alu_inA),
    .alu_inB      (alu_inB),
    .alu_out      (alu_out),
    .alu_cc       (alu_cc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational ALU model: {Z,C,N,V}
  logic        m_c;
  logic [16:0] m_sum;
  always_comb begin
    m_sum   = {1'b0, alu_inA} + {1'b0, alu_inB};
    alu_out = alu_inA;
    m_c     = 1'b0;
    case (alu_op)
      F_A_PLUS_B: begin alu_out = m_sum[15:0];          m_c = m_sum[16];   end
      F_A_SHL:    begin alu_out = {alu_inA[14:0], 1'b0}; m_c = alu_inA[15]; end
      F_A_LSHR:   begin alu_out = {1'b0, alu_inA[15:1]}; m_c = alu_inA[0];  end
      default:    begin alu_out = alu_inA;               m_c = 1'b0;        end
    endcase
    alu_cc = {(alu_out == 16'h0000), m_c, alu_out[15], 1'b0};
  end

  // Results of the last do_mult run (index = edges since the accepting edge)
  alu_op_t     trace [0:63];
  int          done_edge;
  int          done_cnt;
  int          busy_cyc;
  int          plus_cnt;
  logic [15:0] res_p;
  logic        res_o;

  // Launch one multiply and observe until the sequencer returns to idle.
  // restart_mask[k]=1 re-asserts start (with junk operands) for edge k.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                         input logic [63:0] restart_mask);
    done_edge = -1; done_cnt = 0; busy_cyc = 0; plus_cnt = 0;
    res_p = 16'hxxxx; res_o = 1'bx;
    multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; multiplicand = 16'hDEAD; multiplier = 16'hBEEF;
    for (int e = 0; e < 64; e++) begin
      trace[e] = alu_op;
      if (alu_op == F_A_PLUS_B) plus_cnt++;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; done_edge = e; res_p = product; res_o = overflow;
      end
      if (!busy && e > 0) break;
      if (e < 63) start = restart_mask[e+1];
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_L = 1'b0; start = 1'b0; multiplicand = 16'h0; multiplier = 16'h0;
    repeat (2) @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (product !== 16'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", product); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (alu_op !== F_A) begin n_fail++; $display("FAIL reset_alu_op got=%h exp=%h", alu_op, F_A); end
    n_checks++; if (alu_inA !== 16'h0 || alu_inB !== 16'h0) begin
      n_fail++; $display("FAIL reset_alu_in got=%h/%h exp=0000/0000", alu_inA, alu_inB);
    end
    @(negedge clock); reset_L = 1'b1;
  endtask

  task automatic test_3x5;
    do_mult(16'h0003, 16'h0005, 64'h0);
    n_checks++; if (done_edge != 9) begin n_fail++; $display("FAIL 3x5_done_edge got=%0d exp=9", done_edge); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL 3x5_done_pulses got=%0d exp=1", done_cnt); end
    n_checks++; if (res_p !== 16'h000F) begin n_fail++; $display("FAIL 3x5_product got=%h exp=000f", res_p); end
    n_checks++; if (res_o !== 1'b0) begin n_fail++; $display("FAIL 3x5_overflow got=%b exp=0", res_o); end
    n_checks++; if (busy_cyc != 10) begin n_fail++; $display("FAIL 3x5_busy_cycles got=%0d exp=10", busy_cyc); end
    repeat (3) @(posedge clock); #1;
    n_checks++; if (product !== 16'h000F) begin n_fail++; $display("FAIL 3x5_product_hold got=%h exp=000f", product); end
  endtask

  task automatic test_zero_multiplier;
    do_mult(16'h1234, 16'h0000, 64'h0);
    n_checks++; if (done_edge != 0) begin n_fail++; $display("FAIL zero_done_edge got=%0d exp=0", done_edge); end
    n_checks++; if (res_p !== 16'h0000) begin n_fail++; $display("FAIL zero_product got=%h exp=0000", res_p); end
    n_checks++; if (res_o !== 1'b0) begin n_fail++; $display("FAIL zero_overflow got=%b exp=0", res_o); end
    n_checks++; if (plus_cnt != 0) begin n_fail++; $display("FAIL zero_plus_ops got=%0d exp=0", plus_cnt); end
    n_checks++; if (busy_cyc != 1) begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=1", busy_cyc); end
  endtask

  task automatic test_overflow;
    logic [15:0] ta [0:2];
    logic [15:0] tb [0:2];
    logic [15:0] tp [0:2];
    logic        to [0:2];
    ta = '{16'h0100, 16'h8000, 16'h8000};
    tb = '{16'h0100, 16'h0001, 16'h0002};
    tp = '{16'h0000, 16'h8000, 16'h0000};
    to = '{1'b1,     1'b0,     1'b1};
    for (int i = 0; i < 3; i++) begin
      do_mult(ta[i], tb[i], 64'h0);
      n_checks++; if (res_p !== tp[i]) begin
        n_fail++; $display("FAIL ovf%0d_product got=%h exp=%h", i, res_p, tp[i]);
      end
      n_checks++; if (res_o !== to[i]) begin
        n_fail++; $display("FAIL ovf%0d_overflow got=%b exp=%b", i, res_o, to[i]);
      end
    end
  endtask

  task automatic test_max_operands;
    do_mult(16'hFFFF, 16'hFFFF, 64'h0);
    n_checks++; if (done_edge != 48) begin n_fail++; $display("FAIL max_done_edge got=%0d exp=48", done_edge); end
    n_checks++; if (res_p !== 16'h0001) begin n_fail++; $display("FAIL max_product got=%h exp=0001", res_p); end
    n_checks++; if (res_o !== 1'b1) begin n_fail++; $display("FAIL max_overflow got=%b exp=1", res_o); end
  endtask

  task automatic test_start_while_busy;
    do_mult(16'h0003, 16'h0005, 64'h24);  // start re-pulsed for edges 2 and 5
    n_checks++; if (done_edge != 9) begin n_fail++; $display("FAIL abuse_done_edge got=%0d exp=9", done_edge); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL abuse_done_pulses got=%0d exp=1", done_cnt); end
    n_checks++; if (res_p !== 16'h000F) begin n_fail++; $display("FAIL abuse_product got=%h exp=000f", res_p); end
  endtask

  task automatic test_reset_mid_op;
    int dn;
    dn = 0;
    multiplicand = 16'h0003; multiplier = 16'h0005; start = 1'b1;
    @(posedge clock); #1;  // edge 0
    start = 1'b0;
    repeat (4) @(posedge clock);  // edge 4
    #1 reset_L = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    n_checks++; if (product !== 16'h0) begin n_fail++; $display("FAIL midreset_product got=%h exp=0000", product); end
    repeat (2) @(posedge clock);
    @(negedge clock); reset_L = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done) dn++;
    end
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL midreset_done_pulses got=%0d exp=0", dn); end
  endtask

  task automatic test_alu_trace;
    alu_op_t exp_ops [0:5];
    exp_ops = '{F_A_PLUS_B, F_A_SHL, F_A_LSHR, F_A_PLUS_B, F_A_SHL, F_A_LSHR};
    do_mult(16'h0006, 16'h0003, 64'h0);
    for (int e = 0; e < 6; e++) begin
      n_checks++; if (trace[e] !== exp_ops[e]) begin
        n_fail++; $display("FAIL trace_op[%0d] got=%h exp=%h", e, trace[e], exp_ops[e]);
      end
    end
    n_checks++; if (res_p !== 16'h0012) begin n_fail++; $display("FAIL trace_product got=%h exp=0012", res_p); end
    n_checks++; if (done_edge != 6) begin n_fail++; $display("FAIL trace_done_edge got=%0d exp=6", done_edge); end
  endtask

  // start held high across two ops: the second must be taken at edge 3n+2.
  task automatic test_back_to_back;
    int          d1_edge, d2_edge, dn;
    logic [15:0] d1_p, d2_p;
    logic        b10, b11;
    d1_edge = -1; d2_edge = -1; dn = 0; d1_p = 16'hx; d2_p = 16'hx; b10 = 1'bx; b11 = 1'bx;
    multiplicand = 16'h0003; multiplier = 16'h0005; start = 1'b1;
    for (int e = 0; e < 22; e++) begin
      @(posedge clock); #1;
      if (e == 0) begin multiplicand = 16'h0002; multiplier = 16'h0003; end
      if (e == 12) start = 1'b0;
      if (e == 10) b10 = busy;
      if (e == 11) b11 = busy;
      if (done) begin
        dn++;
        if (dn == 1) begin d1_edge = e; d1_p = product; end
        else begin d2_edge = e; d2_p = product; end
      end
    end
    n_checks++; if (d1_edge != 9 || d1_p !== 16'h000F) begin
      n_fail++; $display("FAIL b2b_first got=edge%0d/%h exp=edge9/000f", d1_edge, d1_p);
    end
    n_checks++; if (b10 !== 1'b0 || b11 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept_edge busy10/11 got=%b/%b exp=0/1", b10, b11);
    end
    n_checks++; if (d2_edge != 17 || d2_p !== 16'h0006) begin
      n_fail++; $display("FAIL b2b_second got=edge%0d/%h exp=edge17/0006", d2_edge, d2_p);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_3x5();
    test_zero_multiplier();
    test_overflow();
    test_max_operands();
    test_start_while_busy();
    test_reset_mid_op();
    test_alu_trace();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mult_sequencer.md
# alu_mult_sequencer

Multi-cycle unsigned 16x16 multiply controller for the p18240 datapath. It owns the ALU ports while busy and drives shift-and-add steps through them: F_A_PLUS_B or F_A, then F_A_SHL, then F_A_LSHR. It terminates early once the remaining multiplier is zero. It returns the low 16 bits of the product plus a sticky unsigned-overflow flag, with a start/busy/done handshake to the control FSM.

## Interface
- No parameters. Width is fixed at 16 to match the ALU.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  16  unsigned operand A; captured when start is accepted.
- multiplier  in  16  unsigned operand B; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- product  out  16  low 16 bits of A*B; holds until the next accepted start.
- overflow  out  1  true product is at least 2^16; holds with product.
- alu_op  out  alu_op_t  opcode to the ALU.
- alu_inA  out  16  ALU input A.
- alu_inB  out  16  ALU input B.
- alu_out  in  16  ALU result; the ALU is combinational, same cycle.
- alu_cc  in  4  ALU {Z,C,N,V}.

## Operation
- Internal registers:
  - acc (16): running product.
  - mc (16): shifted multiplicand.
  - mp (16): shifted multiplier.
  - lost (1): a 1 was shifted out of mc.
  - ovf (1): sticky overflow.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE: ALU driven with F_A, inA=0, inB=0. On start=1:
  - acc<=0, mc<=multiplicand, mp<=multiplier, lost<=0, ovf<=0.
  - Next state is DONE if multiplier==0, else ADD.
- ADD:
  - If mp[0]=1: op=F_A_PLUS_B, inA=acc, inB=mc; acc<=alu_out; ovf<=ovf | alu_cc[2] (C) | lost.
  - If mp[0]=0: op=F_A, inA=acc; acc unchanged.
  - Next state: SHL.
- SHL: op=F_A_SHL, inA=mc; mc<=alu_out; lost<=lost | alu_cc[2]. Next state: SHR.
- SHR: op=F_A_LSHR, inA=mp; mp<=alu_out. Next state is DONE if alu_cc[3] (Z)=1, else ADD.
- DONE: done=1; product<=acc and overflow<=ovf are already visible, because product/overflow are driven from acc/ovf. Next state: IDLE.
- Unused ALU inputs are driven to 0 in every state.
- Overflow rule: any carry out of an add, or any add performed after a multiplicand bit was lost, sets overflow. A lost bit with no later add does not set it.
- start while busy is ignored. Operands are not re-sampled mid-operation.
- Arithmetic is unsigned only. The N and V condition codes are ignored.

## Timing
- Reset (asynchronous, reset_L=0):
  - state=IDLE.
  - acc, mc, mp = 0; lost, ovf = 0.
  - busy=0, done=0, product=0, overflow=0.
  - alu_op=F_A, alu_inA=0, alu_inB=0.
- Reset asserted mid-operation aborts immediately. No done pulse; the result is discarded.
- Let n = (index of highest set bit of multiplier) + 1, with n in 1..16.
- start sampled at edge 0:
  - busy rises after edge 0.
  - done is high for exactly the cycle after edge 3n. Maximum is 48 cycles.
  - Next start is accepted at edge 3n+2 at the earliest.
- multiplier==0: done is high in the cycle after edge 0, with product=0 and overflow=0.
- product and overflow are stable from the DONE cycle until the edge after the next accepted start. They clear to 0 at that edge.
- All outputs are registered or decoded from the state only. There are no combinational paths from start to busy or done.

## Test plan
- 3 x 5: start with A=0x0003, B=0x0005 (n=3) -> done in the cycle after edge 9; product=0x000F, overflow=0; busy high for 10 cycles.
- Zero multiplier: A=0x1234, B=0x0000 -> done in the cycle after edge 0; product=0, overflow=0; the ALU never sees F_A_PLUS_B.
- Overflow boundaries:
  - A=0x0100, B=0x0100 -> product=0x0000, overflow=1.
  - A=0x8000, B=0x0001 -> product=0x8000, overflow=0 (lost bit with no later add).
  - A=0x8000, B=0x0002 -> overflow=1.
- Max operands: A=0xFFFF, B=0xFFFF -> n=16, done in the cycle after edge 48; product=0x0001, overflow=1.
- Handshake abuse and reset:
  - Pulse start again at edges 2 and 5 of a 3x5 run -> ignored; result unchanged.
  - Assert reset_L=0 at edge 4 of a run -> busy=0, product=0 immediately, and no done pulse.
- ALU trace: for A=0x0006, B=0x0003, check the per-cycle alu_op sequence PLUS_B, SHL, LSHR, PLUS_B, SHL, LSHR -> product=0x0012.
